// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter/sequencer for a 64Kx16 BasicRAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority where port 0 always wins contention.
module ram_arbiter (
  input  logic        cl,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] ad0,
  input  logic [15:0] ad1,
  input  logic [15:0] d0,
  input  logic [15:0] d1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] q,
  output logic        ram_st,
  output logic [15:0] ram_ad,
  output logic [15:0] ram_X,
  input  logic [15:0] ram_Y
);
  logic w_sel, w_xfer;
  logic r_v1, r_id1, r_v2, r_id2;
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign w_sel = !req0;
`else
  logic r_last;
  assign w_sel = (req0 && req1) ? !r_last : req1;
  always_ff @(posedge cl)
    if (rst) r_last <= 1'b1;
    else if (w_xfer) r_last <= w_sel;
`endif
  assign gnt0   = req0 && !w_sel && !rst;
  assign gnt1   = req1 && w_sel && !rst;
  assign w_xfer = gnt0 || gnt1;
  // Two tag stages track the RAM's one-cycle registered read before q captures it.
  always_ff @(posedge cl) begin
    if (rst) begin
      ram_st  <= 1'b0;
      ram_ad  <= '0;
      ram_X   <= '0;
      q       <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      r_v1    <= 1'b0;
      r_id1   <= 1'b0;
      r_v2    <= 1'b0;
      r_id2   <= 1'b0;
    end else begin
      ram_st  <= w_xfer && (w_sel ? we1 : we0);
      r_v1    <= w_xfer && !(w_sel ? we1 : we0);
      if (w_xfer) begin
        ram_ad <= w_sel ? ad1 : ad0;
        ram_X  <= w_sel ? d1 : d0;
        r_id1  <= w_sel;
      end
      r_v2    <= r_v1;
      r_id2   <= r_id1;
      rvalid0 <= r_v2 && !r_id2;
      rvalid1 <= r_v2 && r_id2;
      if (r_v2) q <= ram_Y;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a read-return scoreboard and a behavioural BasicRAM.
module tb_ram_arbiter;
  logic        cl, rst, req0, req1, we0, we1;
  logic [15:0] ad0, ad1, d0, d1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_st;
  logic [15:0] q, ram_ad, ram_X, ram_Y;

  typedef struct {logic id; logic [15:0] data; int due;} exp_t;
  exp_t        sb[$];
  logic [15:0] ram_mem [0:65535];
  logic [15:0] model_mem [0:65535];
  logic        m_last = 1'b1;
  logic        run = 1'b0;
  int          n = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  ram_arbiter dut (
    .cl(cl), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .ad0(ad0), .ad1(ad1), .d0(d0), .d1(d1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .q(q), .ram_st(ram_st),
    .ram_ad(ram_ad), .ram_X(ram_X), .ram_Y(ram_Y)
  );

  always #5 cl = ~cl;
  always @(posedge cl) n <= n + 1;

  // BasicRAM: commit on falling edge, registered read on rising edge
  always @(negedge cl) if (ram_st === 1'b1) ram_mem[ram_ad] <= ram_X;
  always @(posedge cl) ram_Y <= ram_mem[ram_ad];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  always @(negedge cl) begin
    if (run) begin
      if (sb.size() != 0 && sb[0].due == n) begin
        exp_t e;
        e = sb.pop_front();
        chk1("rvalid0", rvalid0, !e.id);
        chk1("rvalid1", rvalid1, e.id);
        chk("q", q, e.data);
      end else begin
        chk1("rvalid0_idle", rvalid0, 1'b0);
        chk1("rvalid1_idle", rvalid1, 1'b0);
      end
    end
  end

  task automatic step(input logic r,
                      input logic rq0, input logic w0, input logic [15:0] a0, input logic [15:0] x0,
                      input logic rq1, input logic w1, input logic [15:0] a1, input logic [15:0] x1);
    logic e0, e1, id, w;
    logic [15:0] a, x;
    @(negedge cl);
    rst = r; req0 = rq0; we0 = w0; ad0 = a0; d0 = x0;
    req1 = rq1; we1 = w1; ad1 = a1; d1 = x1;
    #1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    e0 = rq0 && !r;
`else
    e0 = rq0 && !r && (!rq1 || m_last);
`endif
    e1 = rq1 && !r && !e0;
    chk1("gnt0", gnt0, e0);
    chk1("gnt1", gnt1, e1);
    if (r) begin
      sb.delete();
      m_last = 1'b1;
    end else if (e0 || e1) begin
      id = e1;
      m_last = id;
      w = id ? w1 : w0;
      a = id ? a1 : a0;
      x = id ? x1 : x0;
      if (w) model_mem[a] = x;
      else sb.push_back('{id, model_mem[a], n + 3});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    cl = 0; rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    ad0 = 0; ad1 = 0; d0 = 0; d1 = 0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0);
    idle();
    run = 1'b1;
    chk1("rst_ram_st", ram_st, 1'b0);
    chk("rst_ram_ad", ram_ad, 16'h0);
    chk("rst_ram_X", ram_X, 16'h0);
    chk("rst_q", q, 16'h0);
    chk1("rst_rvalid0", rvalid0, 1'b0);
    chk1("rst_rvalid1", rvalid1, 1'b0);
    // preload
    step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0002, 16'h2222);
    step(1'b0, 1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0);
    // write then read
    step(1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) idle();
    // back-to-back write (port 1) then read (port 0)
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'hFFFF, 16'hA5A5);
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    chk1("b2b_st_hi", ram_st, 1'b1);
    chk("b2b_ad", ram_ad, 16'hFFFF);
    chk("b2b_X", ram_X, 16'hA5A5);
    idle();
    chk1("b2b_st_lo", ram_st, 1'b0);
    repeat (2) idle();
    // reset mid-read, with a write offered during reset
    step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0020, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    chk1("mid_rst_rvalid0", rvalid0, 1'b0);
    chk("mid_rst_q", q, 16'h0);
    // contention right after reset: port 0 first, then alternate
    repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0, 1'b1, 1'b0, 16'h0002, 16'h0);
    repeat (3) idle();
    step(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) idle();
    // write accepted the edge before reset still commits
    step(1'b0, 1'b1, 1'b1, 16'h0030, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle();
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0);
    repeat (3) idle();
    // idle hold
    step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h9999);
    idle();
    chk1("hold_st_pulse", ram_st, 1'b1);
    repeat (4) begin
      idle();
      chk1("hold_st", ram_st, 1'b0);
      chk("hold_ad", ram_ad, 16'h0040);
      chk("hold_X", ram_X, 16'h9999);
    end
    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the 64K×16 `BasicRAM`. Sits between two masters (instruction-fetch and data ports of the CPU) and the single RAM port. Arbitrates round-robin, registers address/data/store toward the RAM, and returns read data with a fixed latency. Sustains one access per clock.

## Interface
Parameters:
- none (data and address width fixed at 16)

Ports:
- `cl` in 1: clock. One clock domain; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0` / `req1` in 1: requester i has a valid access pending. Held, with `we`/`ad`/`d`, until the cycle `gnt_i`=1.
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `ad0` / `ad1` in 16: word address.
- `d0` / `d1` in 16: write data. Ignored on reads.
- `gnt0` / `gnt1` out 1: combinational. Request accepted at the next rising edge.
- `rvalid0` / `rvalid1` out 1: registered. One-cycle pulse; `q` holds read data for requester i.
- `q` out 16: registered read data, shared by both requesters.
- `ram_st` out 1: registered. To RAM `st`.
- `ram_ad` out 16: registered. To RAM `ad`.
- `ram_X` out 16: registered. To RAM `X`.
- `ram_Y` in 16: from RAM `Y`. Registered inside the RAM on the rising edge.

## Operation
- Grant logic:
  - `gnt_i = req_i && sel==i && !rst`. At most one grant per cycle.
  - Transfer happens at the rising edge where `gnt_i`=1.
- Arbitration: pointer `last` (0/1).
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester ≠ `last` wins.
  - `last` updates to the winner on every transfer; otherwise unchanged.
- Issue stage, at a transfer edge:
  - `ram_ad` ← `ad_i`.
  - `ram_X` ← `d_i`.
  - `ram_st` ← `we_i`.
  - Tag pipeline stage 1 ← {valid = !`we_i`, id = i}.
- Issue stage, no transfer:
  - `ram_st` ← 0.
  - `ram_ad` and `ram_X` hold their values.
  - Stage-1 valid ← 0.
- Write commit: the RAM commits on the falling edge inside the cycle following the transfer. `ram_st` is high for exactly that one cycle.
- Read return:
  - RAM updates `Y` at edge E+1 (E = transfer edge).
  - Tag stage 2 ← stage 1 at E+1.
  - At E+2: `q` ← `ram_Y`, `rvalid_id` ← stage-2 valid.
  - `q` holds its value when no read returns.
- Reset (edge with `rst`=1):
  - `last`←1, so port 0 wins the first contention.
  - `ram_st`←0, `ram_ad`←0, `ram_X`←0, `q`←0.
  - `rvalid0`/`rvalid1`←0. Both tag stages invalidated.
  - `gnt0`/`gnt1` are 0 while `rst`=1.
- Reset mid-operation: in-flight reads are dropped with no `rvalid`. A write accepted at the edge before reset already has `ram_st`=1 and commits; a request presented in the reset cycle is not accepted.

## Timing
- Grant: combinational, same cycle as `req`.
- Write latency: data in memory by the falling edge after the transfer edge E.
- Read latency: `rvalid_i`/`q` valid in the cycle after edge E+2. Fixed at 2 cycles.
- Throughput: one transfer per cycle. Back-to-back transfers from either or both requesters are allowed.
- Read-after-write, same address, consecutive transfers (write at E, read at E+1): the read returns the new data at E+3.
- Read and write ordering is strictly transfer order.
- Fairness: under continuous contention, grants alternate 0,1,0,1… Neither requester waits more than 1 cycle.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins contention. `last` is not implemented.
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `req0`=`req1`=1 → `gnt0`=`gnt1`=0 throughout. After the reset edge: all registered outputs 0, no RAM write.
- Single write then read: port 0 writes 0xBEEF to 0x0010, then reads 0x0010 on the next cycle → `rvalid0`=1, `q`=0xBEEF exactly 2 edges after the read transfer. `rvalid1` stays 0.
- Contention: both ports continuously read (port 0 at 0x0001=0x1111, port 1 at 0x0002=0x2222) → grants 0,1,0,1. `rvalid` alternates 0/1 with matching `q`. With the macro defined → `gnt1` never asserts.
- Back-to-back mixed: port 1 writes 0xA5A5 to 0xFFFF, port 0 immediately reads 0xFFFF → the read returns 0xA5A5. `ram_st` is high for exactly 1 cycle.
- Reset mid-read: read accepted at E, `rst`=1 at E+1 → no `rvalid` at E+2. `q`=0 after reset.
- Idle hold: no requests for 4 cycles after a write → `ram_st`=0, and `ram_ad`/`ram_X` hold their last values.
